wb_line_refill: RTL and testbench
=================================

Name: wb_line_refill

Overview:
- Wishbone B3 burst read master that refills one cache line from a B3 registered-feedback RAM slave. It sits directly upstream of that slave.
- Accepts a single line-refill request and issues a critical-word-first wrapping incrementing burst (CTI 010, BTE wrap-4/8/16).
- Presents the correct wrapped address on every beat and terminates the burst with CTI 111.
- Streams returned words to the cache with per-beat valid, last and error flags.

Parameters:
- dw, 32, data width; only 32 is supported.
- aw, 32, address width.
- burst_len, 4, beats per line; legal values 4, 8, 16. Any other value is a compile-time error.

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  reset; asynchronous, active-high
- req_valid_i  in  1  refill request
- req_adr_i  in  aw  critical-word byte address; bits [1:0] ignored
- req_ready_o  out  1  request accepted when high together with req_valid_i
- rsp_valid_o  out  1  one returned word this cycle
- rsp_dat_o  out  dw  returned word
- rsp_adr_o  out  aw  byte address of rsp_dat_o
- rsp_last_o  out  1  final beat of the line
- rsp_err_o  out  1  burst aborted by bus error
- wbm_adr_o  out  aw  Wishbone address
- wbm_sel_o  out  4  constant 4'hf
- wbm_we_o  out  1  constant 0
- wbm_cti_o  out  3  cycle type
- wbm_bte_o  out  2  burst type
- wbm_cyc_o  out  1  cycle
- wbm_stb_o  out  1  strobe
- wbm_dat_i  in  dw  read data
- wbm_ack_i  in  1  acknowledge
- wbm_err_i  in  1  error
- wbm_rty_i  in  1  retry

Behaviour:
- Reset (asynchronous): state IDLE.
  - wbm_cyc_o, wbm_stb_o, rsp_valid_o, rsp_last_o, rsp_err_o = 0.
  - wbm_cti_o = 000, wbm_bte_o = 00, wbm_adr_o = 0, beat counter = 0.
  - req_ready_o = 1 (decoded from IDLE).
- FSM states: IDLE, BURST.
- IDLE:
  - req_ready_o = 1.
  - On req_valid_i, latch req_adr_i with bits [1:0] forced to 00 and go to BURST.
  - cyc, stb and adr are registered and appear the cycle after acceptance (1-cycle request latency).
- BURST:
  - cyc = stb = 1 continuously; no idle beats are inserted.
  - bte = 01/10/11 for burst_len 4/8/16.
  - cti = 010 while beats_remaining > 1, and 111 on the final beat.
- On wbm_ack_i:
  - Register rsp_valid_o = 1 next cycle with rsp_dat_o = wbm_dat_i, rsp_adr_o = current adr, rsp_last_o = (final beat).
  - Advance adr: word index bits [log2(burst_len)+1:2] increment modulo burst_len; upper bits are unchanged.
  - Increment the beat counter.
- Final-beat ack:
  - Deassert cyc/stb at the same clock edge, cti returns to 000, go to IDLE.
  - A new request is accepted no earlier than the cycle after the final ack.
- Wait states: ack low holds adr, cti and counter unchanged.
- wbm_err_i or wbm_rty_i (rty is treated as err) in BURST:
  - Drop cyc/stb at the next edge.
  - Pulse rsp_err_o for 1 cycle with rsp_valid_o = 0 and rsp_last_o = 0.
  - Go to IDLE; no further beats are issued and the line is discarded by the consumer.
- Simultaneous ack and err: err wins; that beat's data is not forwarded.
- The response side has no backpressure. The consumer must accept one word per cycle.
- rsp_valid_o, rsp_last_o and rsp_err_o are single-cycle pulses.
- Reset asserted mid-burst: cyc/stb drop immediately (asynchronous); no response pulse is produced.
- wbm_adr_o must always equal the slave's internal burst address. Any mismatch causes the slave to return err, and that condition is a verification failure.

Decomposition:
- Shared package wb_b3_pkg:
  - CTI constants: CLASSIC = 000, CONST = 001, INCR = 010, EOB = 111.
  - BTE constants: LINEAR = 00, WRAP4 = 01, WRAP8 = 10, WRAP16 = 11.
  - Function burst_len_to_bte.
- One sub-module, wb_wrap_adr_gen:
  - Combinational wrapped next-address calculation from the current address and BTE.
  - Reusable by a future line write-back master.

Test Plan:
- burst_len=4, req_adr 0x108, zero-wait slave -> wbm_adr 0x108, 0x10C, 0x100, 0x104; cti 010, 010, 010, 111; bte 01; rsp_last only with rsp_adr 0x104; cyc low the cycle after the 4th ack.
- burst_len=8, req_adr 0x21C, slave inserts 2 wait states on beat 3 -> address sequence 0x21C, 0x200 … 0x218 with adr held during the waits; 8 rsp_valid pulses with data matching preloaded memory.
- burst_len=4, wbm_err_i on beat 2 -> exactly 1 rsp_valid (beat 1), 1-cycle rsp_err_o, no rsp_last, cyc low next cycle, req_ready_o = 1.
- Two back-to-back requests (0x0, then 0x40, req_valid held high) -> second cyc rises 1 cycle after the first burst's final ack; 8 total responses in order; no gap within a burst.
- wb_rst_i asserted asynchronously mid-beat 2 -> cyc/stb/rsp outputs 0 before the next clock edge; after release, a request to 0x10 completes normally.
- Request with req_adr 0x10B -> treated as 0x108; sel stays 4'hf and we stays 0 throughout.

Source files
------------

// File: rtl/wb_b3_pkg.sv
// Wishbone B3 cycle-type and burst-type encodings, plus the refill FSM state type.
package wb_b3_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_CONST   = 3'b001;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [1:0] BTE_LINEAR = 2'b00;
    localparam logic [1:0] BTE_WRAP4  = 2'b01;
    localparam logic [1:0] BTE_WRAP8  = 2'b10;
    localparam logic [1:0] BTE_WRAP16 = 2'b11;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } refill_state_e;

    function automatic logic [1:0] burst_len_to_bte(input int unsigned len);
        logic [1:0] bte;
        case (len)
            4:       bte = BTE_WRAP4;
            8:       bte = BTE_WRAP8;
            16:      bte = BTE_WRAP16;
            default: bte = BTE_LINEAR;
        endcase
        return bte;
    endfunction

endpackage

// File: rtl/wb_wrap_adr_gen.sv
// Next byte address of a B3 incrementing burst: linear, or wrapping inside a 4/8/16-word block.
module wb_wrap_adr_gen
    import wb_b3_pkg::*;
#(
    parameter int aw = 32
) (
    input  logic [aw-1:0] adr_i,
    input  logic [1:0]    bte_i,
    output logic [aw-1:0] nxt_adr_o
);

    always_comb begin
        nxt_adr_o = adr_i;
        case (bte_i)
            BTE_WRAP4:  nxt_adr_o[3:2] = adr_i[3:2] + 2'd1;
            BTE_WRAP8:  nxt_adr_o[4:2] = adr_i[4:2] + 3'd1;
            BTE_WRAP16: nxt_adr_o[5:2] = adr_i[5:2] + 4'd1;
            default:    nxt_adr_o      = adr_i + aw'(4);
        endcase
    end

endmodule

// File: rtl/wb_line_refill.sv
// Cache line refill master: one critical-word-first wrapping B3 burst per request,
// returned words streamed out as single-cycle valid/last/err pulses.
//
//   state    | meaning
//   ST_IDLE  | ready for a request, bus idle
//   ST_BURST | cyc/stb asserted, collecting burst_len beats
module wb_line_refill
    import wb_b3_pkg::*;
#(
    parameter int dw        = 32,
    parameter int aw        = 32,
    parameter int burst_len = 4
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          req_valid_i,
    input  logic [aw-1:0] req_adr_i,
    output logic          req_ready_o,
    output logic          rsp_valid_o,
    output logic [dw-1:0] rsp_dat_o,
    output logic [aw-1:0] rsp_adr_o,
    output logic          rsp_last_o,
    output logic          rsp_err_o,
    output logic [aw-1:0] wbm_adr_o,
    output logic [3:0]    wbm_sel_o,
    output logic          wbm_we_o,
    output logic [2:0]    wbm_cti_o,
    output logic [1:0]    wbm_bte_o,
    output logic          wbm_cyc_o,
    output logic          wbm_stb_o,
    input  logic [dw-1:0] wbm_dat_i,
    input  logic          wbm_ack_i,
    input  logic          wbm_err_i,
    input  logic          wbm_rty_i
);

    localparam int         BW  = $clog2(burst_len);
    localparam logic [1:0] BTE = burst_len_to_bte(burst_len);

    if (dw != 32) begin : g_bad_dw
        $error("wb_line_refill: only dw = 32 is supported");
    end
    if (burst_len != 4 && burst_len != 8 && burst_len != 16) begin : g_bad_len
        $error("wb_line_refill: burst_len must be 4, 8 or 16");
    end

    refill_state_e state_q;
    logic [aw-1:0] adr_q;
    logic [aw-1:0] adr_d;
    logic [2:0]    cti_q;
    logic [1:0]    bte_q;
    logic          cyc_q;
    logic [BW-1:0] beat_q;
    logic          rsp_valid_q;
    logic          rsp_last_q;
    logic          rsp_err_q;
    logic [dw-1:0] rsp_dat_q;
    logic [aw-1:0] rsp_adr_q;
    logic          final_beat;
    logic          unused_adr_lsb;

    // Byte-lane bits of the request address are dropped; refills are always whole words.
    assign unused_adr_lsb = ^req_adr_i[1:0];
    assign final_beat     = (beat_q == BW'(burst_len - 1));

    wb_wrap_adr_gen #(.aw(aw)) u_adr_gen (
        .adr_i     (adr_q),
        .bte_i     (bte_q),
        .nxt_adr_o (adr_d)
    );

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q     <= ST_IDLE;
            adr_q       <= '0;
            cti_q       <= CTI_CLASSIC;
            bte_q       <= BTE_LINEAR;
            cyc_q       <= 1'b0;
            beat_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_adr_q   <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        adr_q   <= {req_adr_i[aw-1:2], 2'b00};
                        cyc_q   <= 1'b1;
                        cti_q   <= CTI_INCR;
                        bte_q   <= BTE;
                        beat_q  <= '0;
                        state_q <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    // Error takes priority over a coincident ack; that beat's data is dropped.
                    if (wbm_err_i || wbm_rty_i) begin
                        cyc_q     <= 1'b0;
                        cti_q     <= CTI_CLASSIC;
                        bte_q     <= BTE_LINEAR;
                        rsp_err_q <= 1'b1;
                        state_q   <= ST_IDLE;
                    end else if (wbm_ack_i) begin
                        rsp_valid_q <= 1'b1;
                        rsp_dat_q   <= wbm_dat_i;
                        rsp_adr_q   <= adr_q;
                        rsp_last_q  <= final_beat;
                        adr_q       <= adr_d;
                        beat_q      <= beat_q + BW'(1);
                        if (final_beat) begin
                            cyc_q   <= 1'b0;
                            cti_q   <= CTI_CLASSIC;
                            bte_q   <= BTE_LINEAR;
                            state_q <= ST_IDLE;
                        end else if (beat_q == BW'(burst_len - 2)) begin
                            cti_q <= CTI_EOB;
                        end
                    end
                end
            endcase
        end
    end

    assign req_ready_o = (state_q == ST_IDLE);
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_dat_o   = rsp_dat_q;
    assign rsp_adr_o   = rsp_adr_q;
    assign rsp_last_o  = rsp_last_q;
    assign rsp_err_o   = rsp_err_q;
    assign wbm_adr_o   = adr_q;
    assign wbm_sel_o   = 4'hf;
    assign wbm_we_o    = 1'b0;
    assign wbm_cti_o   = cti_q;
    assign wbm_bte_o   = bte_q;
    assign wbm_cyc_o   = cyc_q;
    assign wbm_stb_o   = cyc_q;

endmodule

// File: tb/tb_wb_line_refill.sv
// Bench for wb_line_refill: one instance per legal burst length, each with a wrapping-burst
// RAM slave model, a request driver and a response scoreboard.
module tb_wb_line_refill;

    localparam int NINST = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks    = 0;
    int failures  = 0;
    int done_cnt  = 0;
    logic [31:0] mem [0:1023];

    typedef struct packed {
        logic [31:0]      start;
        logic [15:0][1:0] waits;
        logic [4:0]       err_beat;
        logic             use_rty;
        logic             ack_too;
    } plan_t;

    typedef struct packed {
        logic        err;
        logic        last;
        logic [31:0] adr;
        logic [31:0] dat;
    } rsp_t;

    task automatic chk(input int g, input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL inst%0d %s: got %h expected %h at %0t", g, name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < NINST; g++) begin : g_inst
        localparam int BL      = 4 << g;
        localparam int EXP_BTE = $clog2(BL) - 1;

        logic        rst, req_valid, req_ready;
        logic        rsp_valid, rsp_last, rsp_err;
        logic [31:0] req_adr, rsp_dat, rsp_adr, adr, dat_i;
        logic [3:0]  sel;
        logic        we, cyc, stb, ack, err, rty;
        logic [2:0]  cti;
        logic [1:0]  bte;
        plan_t       plan_q[$];
        rsp_t        exp_q[$];

        wb_line_refill #(.dw(32), .aw(32), .burst_len(BL)) dut (
            .wb_clk_i    (clk),
            .wb_rst_i    (rst),
            .req_valid_i (req_valid),
            .req_adr_i   (req_adr),
            .req_ready_o (req_ready),
            .rsp_valid_o (rsp_valid),
            .rsp_dat_o   (rsp_dat),
            .rsp_adr_o   (rsp_adr),
            .rsp_last_o  (rsp_last),
            .rsp_err_o   (rsp_err),
            .wbm_adr_o   (adr),
            .wbm_sel_o   (sel),
            .wbm_we_o    (we),
            .wbm_cti_o   (cti),
            .wbm_bte_o   (bte),
            .wbm_cyc_o   (cyc),
            .wbm_stb_o   (stb),
            .wbm_dat_i   (dat_i),
            .wbm_ack_i   (ack),
            .wbm_err_i   (err),
            .wbm_rty_i   (rty)
        );

        // Address of beat i of a line refill that starts at word address 'start'.
        function automatic logic [31:0] beat_adr(input logic [31:0] start, input int i);
            logic [31:0] base;
            int          w0;
            base = start & ~(32'(BL * 4) - 32'd1);
            w0   = int'(start[5:2]) % BL;
            return base + 32'(((w0 + i) % BL) * 4);
        endfunction

        function automatic plan_t make_plan(input logic [31:0] a, input int unsigned wait_pct,
                                            input int unsigned err_pct);
            plan_t p;
            p.start = a & 32'hFFFF_FFFC;
            for (int i = 0; i < 16; i++)
                p.waits[i] = ($urandom_range(0, 99) < wait_pct) ? 2'($urandom_range(1, 3)) : 2'd0;
            p.err_beat = ($urandom_range(0, 99) < err_pct) ? 5'($urandom_range(0, BL - 1)) : 5'd31;
            p.use_rty  = 1'($urandom_range(0, 1));
            p.ack_too  = 1'($urandom_range(0, 1));
            return p;
        endfunction

        task automatic push_expected(input plan_t p);
            rsp_t        r;
            logic [31:0] a;
            for (int i = 0; i < BL; i++) begin
                if (i == int'(p.err_beat)) begin
                    r = '0;
                    r.err = 1'b1;
                    exp_q.push_back(r);
                    break;
                end
                a      = beat_adr(p.start, i);
                r.err  = 1'b0;
                r.last = (i == BL - 1);
                r.adr  = a;
                r.dat  = mem[a[11:2]];
                exp_q.push_back(r);
            end
        endtask

        // Called just after a negedge; returns at the negedge following acceptance.
        task automatic issue(input plan_t p, input logic [31:0] a, input bit keep);
            int n;
            push_expected(p);
            plan_q.push_back(p);
            req_adr   = a;
            req_valid = 1'b1;
            n = 0;
            while (req_ready !== 1'b1 && n < 300) begin
                @(negedge clk);
                n++;
            end
            chk(g, "req_ready_seen", 64'(req_ready), 64'd1);
            @(posedge clk);
            @(negedge clk);
            chk(g, "cyc_after_accept", 64'(cyc), 64'd1);
            chk(g, "ready_in_burst", 64'(req_ready), 64'd0);
            if (!keep) req_valid = 1'b0;
        endtask

        task automatic wait_idle();
            int n;
            n = 0;
            while ((cyc !== 1'b0 || exp_q.size() != 0 || plan_q.size() != 0) && n < 400) begin
                @(negedge clk);
                n++;
            end
            chk(g, "drain_exp_q", 64'(exp_q.size()), 64'd0);
        endtask

        initial begin : slave
            plan_t       cur;
            int          beat, wcnt;
            bit          in_burst, ending, drv_ack, drv_err;
            logic [31:0] sa;
            cur = '0; beat = 0; wcnt = 0; sa = '0;
            in_burst = 0; ending = 0; drv_ack = 0; drv_err = 0;
            ack = 1'b0; err = 1'b0; rty = 1'b0; dat_i = '0;
            forever begin
                @(negedge clk);
                if (rst) begin
                    in_burst = 0; ending = 0; drv_ack = 0; drv_err = 0;
                    ack = 1'b0; err = 1'b0; rty = 1'b0;
                end else begin
                    if (in_burst) begin
                        if (drv_err) ending = 1;
                        else if (drv_ack) begin
                            beat++;
                            if (beat == BL) ending = 1;
                            else wcnt = int'(cur.waits[beat]);
                        end
                    end
                    if (ending) begin
                        chk(g, "cyc_low_after_end", 64'(cyc), 64'd0);
                        chk(g, "ready_after_end", 64'(req_ready), 64'd1);
                        in_burst = 0;
                        ending   = 0;
                    end
                    if (!in_burst && cyc === 1'b1) begin
                        if (plan_q.size() == 0) chk(g, "unexpected_cyc", 64'(cyc), 64'd0);
                        else begin
                            cur      = plan_q.pop_front();
                            in_burst = 1;
                            beat     = 0;
                            wcnt     = int'(cur.waits[0]);
                        end
                    end
                    if (in_burst) begin
                        sa = beat_adr(cur.start, beat);
                        chk(g, "wbm_cyc", 64'(cyc), 64'd1);
                        chk(g, "wbm_stb", 64'(stb), 64'd1);
                        chk(g, "wbm_adr", 64'(adr), 64'(sa));
                        chk(g, "wbm_cti", 64'(cti), (beat == BL - 1) ? 64'h7 : 64'h2);
                        chk(g, "wbm_bte", 64'(bte), 64'(EXP_BTE));
                        chk(g, "wbm_sel_we", 64'({sel, we}), 64'h1e);
                        if (cyc !== 1'b1) in_burst = 0;
                    end
                    if (!in_burst) begin
                        ack = 1'b0; err = 1'b0; rty = 1'b0; drv_ack = 0; drv_err = 0;
                    end else if (wcnt > 0) begin
                        wcnt--;
                        ack = 1'b0; err = 1'b0; rty = 1'b0; drv_ack = 0; drv_err = 0;
                    end else if (beat == int'(cur.err_beat)) begin
                        ack = cur.ack_too; err = !cur.use_rty; rty = cur.use_rty;
                        dat_i = $urandom; drv_ack = cur.ack_too; drv_err = 1;
                    end else begin
                        ack = 1'b1; err = 1'b0; rty = 1'b0;
                        dat_i = mem[sa[11:2]]; drv_ack = 1; drv_err = 0;
                    end
                end
            end
        end

        initial begin : monitor
            rsp_t e;
            forever begin
                @(negedge clk);
                if (!rst && (rsp_valid === 1'b1 || rsp_err === 1'b1 || rsp_last === 1'b1)) begin
                    if (exp_q.size() == 0) chk(g, "rsp_unexpected", 64'({rsp_valid, rsp_err, rsp_last}), 64'd0);
                    else begin
                        e = exp_q.pop_front();
                        chk(g, "rsp_err", 64'(rsp_err), 64'(e.err));
                        chk(g, "rsp_valid", 64'(rsp_valid), 64'(!e.err));
                        chk(g, "rsp_last", 64'(rsp_last), 64'(e.last));
                        if (!e.err) begin
                            chk(g, "rsp_adr", 64'(rsp_adr), 64'(e.adr));
                            chk(g, "rsp_dat", 64'(rsp_dat), 64'(e.dat));
                        end
                    end
                end
            end
        end

        initial begin : stim
            plan_t       p;
            logic [31:0] a;
            bit          keep;
            rst = 1'b1; req_valid = 1'b0; req_adr = '0;
            repeat (3) @(negedge clk);
            chk(g, "rst_cyc", 64'(cyc), 64'd0);
            chk(g, "rst_stb", 64'(stb), 64'd0);
            chk(g, "rst_rsp", 64'({rsp_valid, rsp_last, rsp_err}), 64'd0);
            chk(g, "rst_cti_bte", 64'({cti, bte}), 64'd0);
            chk(g, "rst_adr", 64'(adr), 64'd0);
            chk(g, "rst_ready", 64'(req_ready), 64'd1);
            #2 rst = 1'b0;
            @(negedge clk);

            // Critical-word-first wrap; the 8-beat line also stalls two cycles before beat 3.
            a = (BL == 4) ? 32'h108 : (BL == 8) ? 32'h21C : 32'h3F4;
            p = make_plan(a, 0, 0);
            if (BL != 4) p.waits[2] = 2'd2;
            issue(p, a, 0);
            wait_idle();

            p = make_plan(32'h100, 0, 0);
            p.err_beat = 5'd1; p.use_rty = 1'b0; p.ack_too = 1'b0;
            issue(p, 32'h100, 0);
            wait_idle();

            // Retry together with ack on the final beat: error must win.
            p = make_plan(32'h184, 0, 0);
            p.err_beat = 5'(BL - 1); p.use_rty = 1'b1; p.ack_too = 1'b1;
            issue(p, 32'h184, 0);
            wait_idle();

            issue(make_plan(32'h0, 0, 0), 32'h0, 1);
            issue(make_plan(32'h40, 0, 0), 32'h40, 0);
            wait_idle();

            issue(make_plan(32'h10B, 0, 0), 32'h10B, 0);
            wait_idle();

            for (int i = 0; i < 25; i++) begin
                a    = 32'($urandom_range(0, 4095));
                keep = (i < 24) && ($urandom_range(0, 1) == 1);
                issue(make_plan(a, 30, 20), a, keep);
                if (!keep) wait_idle();
            end

            issue(make_plan(32'h10, 0, 0), 32'h10, 0);
            @(negedge clk);
            #2 rst = 1'b1;
            #1;
            chk(g, "async_rst_cyc_stb", 64'({cyc, stb}), 64'd0);
            chk(g, "async_rst_rsp", 64'({rsp_valid, rsp_last, rsp_err}), 64'd0);
            @(negedge clk);
            #3 rst = 1'b0;
            exp_q.delete();
            plan_q.delete();
            @(negedge clk);
            issue(make_plan(32'h10, 0, 0), 32'h10, 0);
            wait_idle();

            done_cnt++;
        end
    end

    initial begin : main
        int n;
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        n = 0;
        while (done_cnt < NINST && n < 20000) begin
            @(posedge clk);
            n++;
        end
        chk(0, "all_instances_done", 64'(done_cnt), 64'(NINST));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
